// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver: FSM state
// encodings, frame constants and the bit-period calculation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clock cycles per bit, rounded to nearest integer.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        longint q;
        q = (longint'(clk_freq) + longint'(baud / 2)) / longint'(baud);
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. Held at zero while i_load is high, otherwise counts
// 0..CLKS_PER_BIT-1 and wraps. o_full marks the last cycle of a bit period,
// o_half marks the cycle half a period after the count started.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CNT_W        = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_full,
    output logic o_half
);

    localparam logic [CNT_W-1:0] FULL_V = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_V = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running period counter, restarted by load or at the end of a period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load || (r_cnt == FULL_V)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_full = (r_cnt == FULL_V);
    assign o_half = (r_cnt == HALF_V);

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART with independent transmitter and receiver sharing one clock.
// TX shifts a latched byte out LSB first; RX synchronizes the line,
// validates the start bit at its centre and samples every bit mid-period.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [IDX_W-1:0]     r_tx_idx;
    logic                 r_tx;
    logic                 r_tx_busy;
    logic                 w_tx_load;
    logic                 w_tx_full;
    logic                 w_tx_half_unused;

    // Counter sits at zero in IDLE so the start bit gets a full period.
    assign w_tx_load = (r_tx_state == TX_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_tx_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tx_load),
        .o_full (w_tx_full),
        .o_half (w_tx_half_unused)
    );

    // TX FSM: registered line output, shift register drained LSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (wr_en && !r_tx_busy) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= tx_data;
                        r_tx_idx   <= '0;
                        r_tx       <= 1'b0;
                        r_tx_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (w_tx_full) begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_full) begin
                        if (r_tx_idx == LAST_IDX) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 1'b1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_full) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           r_rx_sync;
    logic                 w_rx_s;
    rx_state_t            r_rx_state;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_err;
    logic                 w_rx_load;
    logic                 w_rx_full;
    logic                 w_rx_half;

    // Two-flop synchronizer; reset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
        end
    end

    assign w_rx_s = r_rx_sync[1];

    // Restart the period at the start-bit centre so later samples land mid-bit.
    assign w_rx_load = (r_rx_state == RX_IDLE) ||
                       ((r_rx_state == RX_START) && w_rx_half);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_rx_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_rx_load),
        .o_full (w_rx_full),
        .o_half (w_rx_half)
    );

    // RX FSM: start-bit validation, mid-bit sampling, stop-bit framing check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_idx   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_half) begin
                        if (w_rx_s) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                            r_rx_idx   <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_full) begin
                        r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == LAST_IDX) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_rx_full) begin
                        r_rx_state <= RX_IDLE;
                        if (w_rx_s) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx using a short bit period (16 clocks).
module tb_uart_txrx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 16;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       loop;
    logic       rx_drv;

    int n_vec;
    int n_err;
    int n_valid;
    int n_rxerr;

    typedef struct {
        logic [7:0] data;
        logic [9:0] wave;    // bit i = expected tx level during bit slot i
        logic       inject;  // fire a second wr_en mid-frame
    } vec_t;

    vec_t vt[6];

    uart_txrx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign rx = loop ? tx : rx_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_err)   n_rxerr++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmit one byte and compare tx cycle by cycle against the expected frame.
    task automatic send_frame(input logic [7:0] d, input logic [9:0] wave,
                              input logic inject, input string tag);
        int v0;
        int e0;
        int bad_cycles;
        int busy_cycles;
        int idle_bad;
        v0 = n_valid;
        e0 = n_rxerr;
        bad_cycles = 0;
        busy_cycles = 0;
        idle_bad = 0;
        @(negedge clk);
        wr_en = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        tx_data = ~d;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (inject && c == 3 * CPB) begin
                wr_en = 1'b1;
                tx_data = 8'h55;
            end else begin
                wr_en = 1'b0;
            end
            if (tx !== wave[c / CPB]) bad_cycles++;
            if (tx_busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        check($sformatf("%s tx bad cycles", tag), 32'(bad_cycles), 32'd0);
        check($sformatf("%s busy cycles", tag), 32'(busy_cycles), 32'(10 * CPB));
        check($sformatf("%s busy after stop", tag), 32'(tx_busy), 32'd0);
        if (loop) begin
            check($sformatf("%s rx_valid pulses", tag), 32'(n_valid - v0), 32'd1);
            check($sformatf("%s rx_data", tag), 32'(rx_data), 32'(d));
            check($sformatf("%s rx_err pulses", tag), 32'(n_rxerr - e0), 32'd0);
        end
        if (inject) begin
            for (int c = 0; c < 2 * CPB; c++) begin
                if (tx !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
                @(posedge clk);
                #1;
            end
            check($sformatf("%s dropped write stays idle", tag), 32'(idle_bad), 32'd0);
        end
    endtask

    // Drive an external frame onto rx with a chosen stop-bit level.
    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            rx_drv = f[s];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    initial begin
        int v0;
        int e0;
        vt[0] = '{data: 8'hF0, wave: 10'h3E0, inject: 1'b0};
        vt[1] = '{data: 8'hA5, wave: 10'h34A, inject: 1'b0};
        vt[2] = '{data: 8'h00, wave: 10'h200, inject: 1'b0};
        vt[3] = '{data: 8'hFF, wave: 10'h3FE, inject: 1'b0};
        vt[4] = '{data: 8'h0F, wave: 10'h21E, inject: 1'b1};
        vt[5] = '{data: 8'h55, wave: 10'h2AA, inject: 1'b0};

        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        wr_en = 1'b0;
        tx_data = 8'h00;
        loop = 1'b1;
        rx_drv = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_err", 32'(rx_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Loopback vectors, sent back to back
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].data, vt[i].wave, vt[i].inject, $sformatf("vec%0d", i));
        end

        // Reset in the middle of the DATA phase
        @(negedge clk);
        wr_en = 1'b1;
        tx_data = 8'hA5;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort tx", 32'(tx), 32'd1);
        check("abort tx_busy", 32'(tx_busy), 32'd0);
        check("abort rx_data", 32'(rx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(8'h3C, 10'h278, 1'b0, "post-reset");

        // External RX: short glitch must be rejected
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        v0 = n_valid;
        e0 = n_rxerr;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch rx_valid", 32'(n_valid - v0), 32'd0);
        check("glitch rx_err", 32'(n_rxerr - e0), 32'd0);

        // Good frame after glitch shows RX returned to IDLE
        v0 = n_valid;
        e0 = n_rxerr;
        drive_frame(8'h96, 1'b1);
        check("ext 0x96 rx_valid", 32'(n_valid - v0), 32'd1);
        check("ext 0x96 rx_data", 32'(rx_data), 32'h96);
        check("ext 0x96 rx_err", 32'(n_rxerr - e0), 32'd0);

        // Framing error: stop bit low
        v0 = n_valid;
        e0 = n_rxerr;
        drive_frame(8'h3C, 1'b0);
        check("ferr rx_err pulses", 32'(n_rxerr - e0), 32'd1);
        check("ferr rx_valid", 32'(n_valid - v0), 32'd0);
        check("ferr rx_data held", 32'(rx_data), 32'h96);

        // Receiver still healthy after the error
        v0 = n_valid;
        e0 = n_rxerr;
        drive_frame(8'h81, 1'b1);
        check("ext 0x81 rx_valid", 32'(n_valid - v0), 32'd1);
        check("ext 0x81 rx_data", 32'(rx_data), 32'h81);
        check("ext 0x81 rx_err", 32'(n_rxerr - e0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
